page_transfer_unit: RTL and testbench

- Sequencer directly upstream of the NAND data IO unit; moves a block of 16-bit words between the page buffer RAM and the IO unit.
- For each word it drives io_type, io_data_out and a one-cycle io_activate pulse, then waits out the IO unit's busy window.
- Sits between the controller's command FSM (start/dir/length) and the IO unit + page buffer.

---
 rtl/page_transfer_unit.sv | 81 ++++++++
 tb/tb_page_transfer_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/page_transfer_unit.sv
// page_transfer_unit: sequences 16-bit word moves between the page buffer and the NAND data IO unit.
module page_transfer_unit #(
    parameter int ADDR_W  = 14,
    parameter int MAX_LEN = 8640
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              dir,
    input  logic [15:0]       length,
    input  logic              abort,
    output logic              io_activate,
    output logic              io_type,
    output logic [15:0]       io_data_out,
    input  logic [15:0]       io_data_in,
    input  logic              io_busy,
    output logic [ADDR_W-1:0] buf_addr,
    output logic              buf_we,
    output logic [15:0]       buf_wdata,
    input  logic [15:0]       buf_rdata,
    output logic              busy,
    output logic              done,
    output logic [15:0]       count
);
    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_HI, WAIT_LO, STORE, FINISH} state_t;
    state_t state, state_n;
    logic        dir_q, abort_q, abort_seen, last;
    logic [15:0] len_q, len_c;
    assign len_c       = (length > 16'(MAX_LEN)) ? 16'(MAX_LEN) : length;
    assign abort_seen  = abort_q | abort;
    assign last        = (count + 16'd1) == len_q;
    assign io_activate = state == ISSUE;
    assign buf_we      = (state == STORE) && !dir_q;
    assign busy        = state != IDLE;
    assign done        = state == FINISH;
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = (len_c == 16'd0) ? FINISH : (dir ? FETCH : ISSUE);
            FETCH:   state_n = abort_seen ? FINISH : ISSUE;
            ISSUE:   state_n = WAIT_HI;
            WAIT_HI: if (io_busy) state_n = WAIT_LO;
            WAIT_LO: if (!io_busy) state_n = STORE;
            STORE:   state_n = (last || abort_seen) ? FINISH : (dir_q ? FETCH : ISSUE);
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // Datapath; the abort flag is sticky for the whole transfer and dropped once back in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            dir_q       <= 1'b0;
            abort_q     <= 1'b0;
            len_q       <= '0;
            io_type     <= 1'b0;
            io_data_out <= '0;
            buf_addr    <= '0;
            buf_wdata   <= '0;
            count       <= '0;
        end else begin
            abort_q <= (state == IDLE) ? 1'b0 : abort_seen;
            if (state == IDLE && start) begin
                dir_q    <= dir;
                io_type  <= dir;
                len_q    <= len_c;
                buf_addr <= '0;
                count    <= '0;
            end
            if (state == FETCH) io_data_out <= buf_rdata;
            if (state == WAIT_LO && !io_busy && !dir_q) buf_wdata <= io_data_in;
            if (state == STORE) begin
                count    <= count + 16'd1;
                buf_addr <= buf_addr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_page_transfer_unit.sv
// tb_page_transfer_unit: table-driven transfers against a behavioural IO unit and page buffer.
module tb_page_transfer_unit;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, dir = 1'b0, abort = 1'b0;
    logic [15:0] length = '0;
    logic        io_activate, io_type, io_busy, buf_we, busy, done;
    logic [15:0] io_data_out, io_data_in, buf_wdata, buf_rdata, count;
    logic [13:0] buf_addr;
    logic [15:0] mem [0:16383];
    logic [15:0] wlog [0:15];
    int acts = 0, wes = 0, dones = 0, reads = 0, wn = 0, t1 = 0, bcnt = 0;
    int checks = 0, errors = 0;

    page_transfer_unit dut (
        .clk(clk), .reset(reset), .start(start), .dir(dir), .length(length), .abort(abort),
        .io_activate(io_activate), .io_type(io_type), .io_data_out(io_data_out),
        .io_data_in(io_data_in), .io_busy(io_busy), .buf_addr(buf_addr), .buf_we(buf_we),
        .buf_wdata(buf_wdata), .buf_rdata(buf_rdata), .busy(busy), .done(done), .count(count)
    );

    always #5 clk = ~clk;
    assign buf_rdata = mem[buf_addr];

    // IO unit: busy rises the cycle after activate and stays high for 3 cycles; read data is 0xA001, 0xA002, ...
    always @(posedge clk) begin
        if (reset) begin
            io_busy    <= 1'b0;
            bcnt       <= 0;
            io_data_in <= '0;
            mem[0]     <= 16'h1111;
            mem[1]     <= 16'h2222;
            mem[2]     <= 16'h3333;
        end else begin
            if (io_activate) begin
                io_busy <= 1'b1;
                bcnt    <= 3;
                acts    <= acts + 1;
                t1      <= t1 + int'(io_type);
                if (io_type) begin
                    if (wn < 16) wlog[wn[3:0]] <= io_data_out;
                    wn <= wn + 1;
                end else begin
                    io_data_in <= 16'hA001 + 16'(reads);
                    reads      <= reads + 1;
                end
            end else if (bcnt > 0) begin
                bcnt <= bcnt - 1;
                if (bcnt == 1) io_busy <= 1'b0;
            end
            if (buf_we) begin
                mem[buf_addr] <= buf_wdata;
                wes <= wes + 1;
            end
            if (done) dones <= dones + 1;
        end
    end

    typedef struct {
        logic d;
        int   len;
        int   abort_w;
        int   ex_count;
        int   ex_acts;
        int   ex_we;
        int   ex_addr;
        bit   spam;
    } vec_t;

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int a0, w0, d0, t0, bud;
        a0 = acts; w0 = wes; d0 = dones; t0 = t1;
        bud = (v.len > 8640 ? 8640 : v.len) * 10 + 30;
        @(negedge clk);
        dir = v.d; length = 16'(v.len); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < bud && dones == d0; c++) begin
            abort = (v.abort_w > 0) && (acts - a0 == v.abort_w) && io_busy;
            if (v.spam) begin
                start  = busy && (c % 7 == 3);
                length = 16'd2;
            end
            @(negedge clk);
        end
        start = 1'b0; abort = 1'b0;
        chk({tag, "_done_seen"}, int'(dones != d0), 1);
        repeat (2) @(negedge clk);
        chk({tag, "_count"}, int'(count), v.ex_count);
        chk({tag, "_acts"}, acts - a0, v.ex_acts);
        chk({tag, "_buf_we"}, wes - w0, v.ex_we);
        chk({tag, "_done_pulses"}, dones - d0, 1);
        chk({tag, "_buf_addr"}, int'(buf_addr), v.ex_addr);
        chk({tag, "_io_type"}, int'(io_type), int'(v.d));
        chk({tag, "_type_at_act"}, t1 - t0, v.d ? v.ex_acts : 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    vec_t vecs[7];
    int a0;

    initial begin
        vecs[0] = '{1'b1, 3,    0, 3,    3,    0,    3,    1'b0};
        vecs[1] = '{1'b0, 4,    0, 4,    4,    4,    4,    1'b0};
        vecs[2] = '{1'b0, 0,    0, 0,    0,    0,    0,    1'b0};
        vecs[3] = '{1'b0, 10,   3, 3,    3,    3,    3,    1'b0};
        vecs[4] = '{1'b1, 5,    1, 1,    1,    0,    1,    1'b0};
        vecs[5] = '{1'b1, 1,    0, 1,    1,    0,    1,    1'b0};
        vecs[6] = '{1'b0, 9000, 0, 8640, 8640, 8640, 8640, 1'b1};
        repeat (3) @(negedge clk);
        chk("rst_ctrl", int'({io_activate, io_type, buf_we, busy, done}), 0);
        chk("rst_data", int'(io_data_out) + int'(buf_wdata) + int'(count) + int'(buf_addr), 0);
        reset = 1'b0;
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
            if (i == 0) begin
                chk("wr_word0", int'(wlog[0]), 16'h1111);
                chk("wr_word1", int'(wlog[1]), 16'h2222);
                chk("wr_word2", int'(wlog[2]), 16'h3333);
            end
            if (i == 1)
                for (int k = 0; k < 4; k++) chk($sformatf("rd_mem%0d", k), int'(mem[k]), 16'hA001 + k);
        end
        // Zero-length request: done follows start by one state, nothing touches the IO unit or buffer.
        a0 = acts;
        @(negedge clk);
        dir = 1'b0; length = 16'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("len0_done_hi", int'(done), 1);
        @(negedge clk);
        chk("len0_done_lo", int'(done), 0);
        chk("len0_idle", int'(busy), 0);
        chk("len0_acts", acts - a0, 0);
        // Reset in the middle of a write word, then a fresh read.
        @(negedge clk);
        dir = 1'b1; length = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 50 && !io_busy; c++) @(negedge clk);
        chk("mid_busy_seen", int'(io_busy), 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_ctrl", int'({io_activate, io_type, buf_we, busy, done}), 0);
        chk("mid_rst_data", int'(io_data_out) + int'(buf_wdata) + int'(count) + int'(buf_addr), 0);
        reset = 1'b0;
        run_vec('{1'b0, 2, 0, 2, 2, 2, 2, 1'b0}, "after_rst");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
